edge_result_serializer: RTL and testbench

//  Downstream of the 3x3-output edge detection core. Captures the nine 8-bit processed sums

---
 rtl/edge_result_serializer_pkg.sv | 31 +++
 rtl/edge_result_serializer_if.sv | 35 +++
 rtl/edge_result_serializer_tile_reg.sv | 47 ++++
 rtl/edge_result_serializer.sv | 196 +++++++++++++++++++
 tb/tb_edge_result_serializer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_result_serializer_pkg.sv
// ============================================================================
// Module : edge_pkg
// Brief  : Shared types and pixel mapping for the edge result serializer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package edge_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned NUM_OUT = 9;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t tile_t [NUM_OUT];

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Unsigned compare; a sum equal to the threshold counts as an edge.
  function automatic pix_t pix_map(input pix_t sum, input logic binarize, input pix_t thresh);
    if (!binarize) begin
      return sum;
    end
    return (sum >= thresh) ? '1 : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_result_serializer_if.sv
// ============================================================================
// Module : edge_result_serializer_if
// Brief  : Valid/ready pixel stream carrying serialized 3x3 tiles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface edge_result_serializer_if;
  import edge_pkg::*;

  logic o_valid;
  pix_t o_pixel;
  logic o_first;
  logic o_last;
  logic i_ready;

  modport master (
    output o_valid,
    output o_pixel,
    output o_first,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_valid,
    input  o_pixel,
    input  o_first,
    input  o_last,
    output i_ready
  );

endinterface

`default_nettype wire

// File: rtl/edge_result_serializer_tile_reg.sv
// ============================================================================
// Module : edge_tile_reg
// Brief  : Nine-pixel load-enable register bank holding one 3x3 tile.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_tile_reg
  import edge_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  tile_t i_data,
  output tile_t o_data
);

  tile_t data_q;
  tile_t data_d;

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      data_d[k] = i_load ? i_data[k] : data_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      o_data[k] = data_q[k];
    end
  end

endmodule

`default_nettype wire

// File: rtl/edge_result_serializer.sv
// ============================================================================
// Module : edge_result_serializer
// Brief  : Captures 3x3 edge results on gradient-ready rise and streams them
//          out in raster order, with one pending tile of buffering.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_result_serializer
  import edge_pkg::*;
#(
  parameter bit          BINARIZE = 1'b0,
  parameter int unsigned THRESH   = 128,
  parameter int unsigned TILE_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_gradient_ready,
  input  logic [7:0]                i_processed_sum_1,
  input  logic [7:0]                i_processed_sum_2,
  input  logic [7:0]                i_processed_sum_3,
  input  logic [7:0]                i_processed_sum_4,
  input  logic [7:0]                i_processed_sum_5,
  input  logic [7:0]                i_processed_sum_6,
  input  logic [7:0]                i_processed_sum_7,
  input  logic [7:0]                i_processed_sum_8,
  input  logic [7:0]                i_processed_sum_9,
  input  logic                      i_clear_overrun,
  edge_result_serializer_if.master  m_if,
  output logic                      o_busy,
  output logic                      o_overrun,
  output logic [TILE_W-1:0]         o_tile_count
);

  localparam logic [3:0] LAST_IDX   = 4'(NUM_OUT - 1);
  localparam pix_t       THRESH_PIX = pix_t'(THRESH);

  ser_state_t        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              ready_q, ready_d;
  logic              p_vld_q, p_vld_d;
  logic              overrun_q, overrun_d;
  logic [TILE_W-1:0] tile_count_q, tile_count_d;
  pix_t              pixel_q, pixel_d;
  logic              first_q, first_d;
  logic              last_q, last_d;

  tile_t sums;
  tile_t a_q;
  tile_t p_q;
  tile_t a_in;
  tile_t a_next;
  logic  a_load;
  logic  a_from_p;
  logic  p_load;
  logic  ev;
  logic  xfer;
  logic  last_xfer;

  always_comb begin
    sums[0] = i_processed_sum_1;
    sums[1] = i_processed_sum_2;
    sums[2] = i_processed_sum_3;
    sums[3] = i_processed_sum_4;
    sums[4] = i_processed_sum_5;
    sums[5] = i_processed_sum_6;
    sums[6] = i_processed_sum_7;
    sums[7] = i_processed_sum_8;
    sums[8] = i_processed_sum_9;
  end

  assign ready_d   = i_gradient_ready;
  assign ev        = i_gradient_ready & ~ready_q;
  assign xfer      = (state_q == SEND) & m_if.i_ready;
  assign last_xfer = xfer & (idx_q == LAST_IDX);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_load       = 1'b0;
    a_from_p     = 1'b0;
    p_load       = 1'b0;
    p_vld_d      = p_vld_q;
    overrun_d    = overrun_q & ~i_clear_overrun;
    tile_count_d = tile_count_q;
    case (state_q)
      IDLE: begin
        if (ev) begin
          a_load  = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_xfer) begin
          tile_count_d = tile_count_q + TILE_W'(1);
          idx_d        = '0;
          // Pending tile goes first; a simultaneous new result refills P behind it.
          if (p_vld_q) begin
            a_load   = 1'b1;
            a_from_p = 1'b1;
            if (ev) begin
              p_load = 1'b1;
            end else begin
              p_vld_d = 1'b0;
            end
          end else if (ev) begin
            a_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + 4'd1;
          end
          if (ev) begin
            if (!p_vld_q) begin
              p_load  = 1'b1;
              p_vld_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output beat is computed from next-cycle A contents so the port flops directly.
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      a_in[k]   = a_from_p ? p_q[k] : sums[k];
      a_next[k] = a_load ? a_in[k] : a_q[k];
    end
    pixel_d = '0;
    first_d = 1'b0;
    last_d  = 1'b0;
    if (state_d == SEND) begin
      pixel_d = pix_map(a_next[idx_d], BINARIZE, THRESH_PIX);
      first_d = (idx_d == 4'd0);
      last_d  = (idx_d == LAST_IDX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ready_q      <= 1'b1;
      p_vld_q      <= 1'b0;
      overrun_q    <= 1'b0;
      tile_count_q <= '0;
      pixel_q      <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ready_q      <= ready_d;
      p_vld_q      <= p_vld_d;
      overrun_q    <= overrun_d;
      tile_count_q <= tile_count_d;
      pixel_q      <= pixel_d;
      first_q      <= first_d;
      last_q       <= last_d;
    end
  end

  edge_tile_reg u_tile_a (
    .clk    (clk),
    .rst    (rst),
    .i_load (a_load),
    .i_data (a_in),
    .o_data (a_q)
  );

  edge_tile_reg u_tile_p (
    .clk    (clk),
    .rst    (rst),
    .i_load (p_load),
    .i_data (sums),
    .o_data (p_q)
  );

  assign m_if.o_valid = (state_q == SEND);
  assign m_if.o_pixel = pixel_q;
  assign m_if.o_first = first_q;
  assign m_if.o_last  = last_q;
  assign o_busy       = (state_q == SEND) | p_vld_q;
  assign o_overrun    = overrun_q;
  assign o_tile_count = tile_count_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_result_serializer.sv
// ============================================================================
// Module : tb_edge_result_serializer
// Brief  : Self-checking bench; two DUTs (pass-through and binarized, narrow
//          tile counter) against a tile-queue reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_edge_result_serializer;
  import edge_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gr  = 1'b0;
  logic clr = 1'b0;
  logic rdy = 1'b0;
  logic [7:0] s [9];

  logic        busy_a, ovr_a, busy_b, ovr_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  edge_result_serializer_if if_a ();
  edge_result_serializer_if if_b ();
  assign if_a.i_ready = rdy;
  assign if_b.i_ready = rdy;

  edge_result_serializer #(.BINARIZE(1'b0), .THRESH(128), .TILE_W(16)) dut_a (
    .clk(clk), .rst(rst), .i_gradient_ready(gr),
    .i_processed_sum_1(s[0]), .i_processed_sum_2(s[1]), .i_processed_sum_3(s[2]),
    .i_processed_sum_4(s[3]), .i_processed_sum_5(s[4]), .i_processed_sum_6(s[5]),
    .i_processed_sum_7(s[6]), .i_processed_sum_8(s[7]), .i_processed_sum_9(s[8]),
    .i_clear_overrun(clr), .m_if(if_a), .o_busy(busy_a), .o_overrun(ovr_a),
    .o_tile_count(cnt_a)
  );

  edge_result_serializer #(.BINARIZE(1'b1), .THRESH(128), .TILE_W(4)) dut_b (
    .clk(clk), .rst(rst), .i_gradient_ready(gr),
    .i_processed_sum_1(s[0]), .i_processed_sum_2(s[1]), .i_processed_sum_3(s[2]),
    .i_processed_sum_4(s[3]), .i_processed_sum_5(s[4]), .i_processed_sum_6(s[5]),
    .i_processed_sum_7(s[6]), .i_processed_sum_8(s[7]), .i_processed_sum_9(s[8]),
    .i_clear_overrun(clr), .m_if(if_b), .o_busy(busy_b), .o_overrun(ovr_b),
    .o_tile_count(cnt_b)
  );

  // Reference model: queue of accepted tiles (head is being sent), beat position in head.
  logic [71:0] mq [$];
  int          pos;
  int          tiles_done;
  bit          m_ovr;
  bit          m_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [71:0] pack_sums();
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = s[i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    pos        = 0;
    tiles_done = 0;
    m_ovr      = 1'b0;
    m_prev     = 1'b1;
  endtask

  task automatic model_edge();
    bit ev;
    bit dropped;
    ev      = gr & ~m_prev;
    m_prev  = gr;
    dropped = 1'b0;
    if (mq.size() > 0 && rdy) begin
      pos++;
      if (pos == 9) begin
        pos = 0;
        void'(mq.pop_front());
        tiles_done++;
      end
    end
    if (ev) begin
      if (mq.size() < 2) mq.push_back(pack_sums());
      else dropped = 1'b1;
    end
    if (dropped) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic check_outputs();
    logic        exp_v;
    logic [71:0] head;
    logic [7:0]  p;
    exp_v = (mq.size() > 0);
    check("valid_a", {31'd0, if_a.o_valid}, {31'd0, exp_v});
    check("valid_b", {31'd0, if_b.o_valid}, {31'd0, exp_v});
    if (exp_v) begin
      head = mq[0];
      p    = head[pos*8 +: 8];
      check("pixel_a", {24'd0, if_a.o_pixel}, {24'd0, p});
      check("pixel_b", {24'd0, if_b.o_pixel}, (p >= 8'd128) ? 32'hFF : 32'h0);
      check("first_a", {31'd0, if_a.o_first}, (pos == 0) ? 32'd1 : 32'd0);
      check("last_a",  {31'd0, if_a.o_last},  (pos == 8) ? 32'd1 : 32'd0);
      check("first_b", {31'd0, if_b.o_first}, (pos == 0) ? 32'd1 : 32'd0);
      check("last_b",  {31'd0, if_b.o_last},  (pos == 8) ? 32'd1 : 32'd0);
    end
    check("busy_a",    {31'd0, busy_a}, {31'd0, exp_v});
    check("busy_b",    {31'd0, busy_b}, {31'd0, exp_v});
    check("overrun_a", {31'd0, ovr_a},  {31'd0, m_ovr});
    check("overrun_b", {31'd0, ovr_b},  {31'd0, m_ovr});
    check("count_a",   {16'd0, cnt_a},  tiles_done % 65536);
    check("count_b",   {28'd0, cnt_b},  tiles_done % 16);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_sums();
    for (int i = 0; i < 9; i++) s[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_capture();
    gr = 1'b0;
    cycle();
    gr = 1'b1;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 9; i++) s[i] = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    cycle();

    // Basic tile 1..9 at full throughput.
    rdy = 1'b1;
    for (int i = 0; i < 9; i++) s[i] = 8'(i + 1);
    gr = 1'b1;
    cycle();
    check("t1_latency", {31'd0, if_a.o_valid}, 32'd1);
    gr = 1'b0;
    repeat (10) cycle();
    check("t1_count", {16'd0, cnt_a}, 32'd1);

    // Threshold boundary values.
    s[0] = 8'd0;   s[1] = 8'd127; s[2] = 8'd128; s[3] = 8'd255; s[4] = 8'd1;
    s[5] = 8'd254; s[6] = 8'd129; s[7] = 8'd126; s[8] = 8'd64;
    pulse_capture();
    gr = 1'b0;
    repeat (10) cycle();

    // Stalls on alternating cycles.
    for (int i = 0; i < 9; i++) s[i] = 8'(10 + i);
    pulse_capture();
    gr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rdy = k[0];
      cycle();
    end
    rdy = 1'b1;
    repeat (3) cycle();

    // Pending tile absorbed while stalled, then back-to-back drain.
    rdy = 1'b0;
    rand_sums();
    pulse_capture();
    rand_sums();
    pulse_capture();
    gr = 1'b0;
    rdy = 1'b1;
    repeat (20) cycle();

    // Third tile while both buffers full is dropped; then clear.
    rdy = 1'b0;
    rand_sums(); pulse_capture();
    rand_sums(); pulse_capture();
    rand_sums(); pulse_capture();
    check("t5_overrun", {31'd0, ovr_a}, 32'd1);
    gr = 1'b0;
    rdy = 1'b1;
    repeat (20) cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    cycle();

    // Asynchronous reset in the middle of a tile.
    rand_sums();
    pulse_capture();
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    model_reset();
    check("t6_valid_a", {31'd0, if_a.o_valid}, 32'd0);
    check("t6_valid_b", {31'd0, if_b.o_valid}, 32'd0);
    check("t6_count",   {16'd0, cnt_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) cycle();
    gr = 1'b0;
    cycle();
    gr = 1'b1;
    cycle();
    gr = 1'b0;
    repeat (12) cycle();

    // Randomized traffic; enough tiles to wrap the 4-bit counter.
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 3) == 0) gr = ~gr;
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rand_sums();
      cycle();
    end
    gr  = 1'b0;
    clr = 1'b0;
    rdy = 1'b1;
    repeat (25) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
